// File: rtl/mon_pkg.sv
// Shared constants and types for the NeXT monitor link (host transmitter and sound-box decoder).
package mon_pkg;

  localparam int unsigned MON_PKT_W = 40;

  localparam logic MON_IDLE_LEVEL  = 1'b1;
  localparam logic MON_START_LEVEL = 1'b0;

  // Opcode byte carried in the top 8 bits of a packet
  localparam int unsigned MON_OP_MSB   = MON_PKT_W - 1;
  localparam logic [7:0]  MON_OP_AUDIO = 8'h07;
  localparam logic [7:0]  MON_OP_LED   = 8'h0F;
  localparam logic [7:0]  MON_OP_ATTEN = 8'h1F;
  localparam logic [7:0]  MON_OP_MIC   = 8'h2F;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StGap
  } mon_state_e;

endpackage

// File: rtl/mon_tx_fifo.sv
// Synchronous packet FIFO; full/empty come from pointers carrying one extra wrap bit.
module mon_tx_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned LvlW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = level_q;

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + LvlW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + LvlW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: empty/full gate every read of it
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mon_packet_transmitter.sv
// Host-side monitor-link serializer: FIFO-buffered packets framed as
// start bit, PKT_W data bits MSB-first, then at least GAP_BITS idle-high cycles.
module mon_packet_transmitter
  import mon_pkg::*;
#(
  parameter int unsigned PKT_W      = MON_PKT_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_BITS   = 8
) (
  input  logic                          mon_clk,
  input  logic                          reset,
  input  logic [PKT_W-1:0]              pkt_data,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic                          tx_enable,
  output logic                          to_mon,
  output logic                          busy,
  output logic                          pkt_sent,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CntMax = (PKT_W > GAP_BITS) ? PKT_W : GAP_BITS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  mon_state_e       state_q, state_d;
  logic [PKT_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             to_mon_q, to_mon_d;
  logic             busy_q, busy_d;
  logic             pkt_sent_q, pkt_sent_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, can_start;
  logic [PKT_W-1:0] fifo_rdata;

  // Ready comes from registered FIFO state only, never from a same-cycle pop
  assign pkt_ready = ~fifo_full;
  assign fifo_push = pkt_valid & pkt_ready;
  assign to_mon    = to_mon_q;
  assign busy      = busy_q;
  assign pkt_sent  = pkt_sent_q;

  mon_tx_fifo #(
    .Width (PKT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (mon_clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (pkt_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    to_mon_d   = MON_IDLE_LEVEL;
    pkt_sent_d = 1'b0;
    fifo_pop   = 1'b0;
    can_start  = tx_enable & ~fifo_empty;
    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = StStart;
          to_mon_d = MON_START_LEVEL;
        end
      end
      StStart: begin
        state_d  = StData;
        cnt_d    = CntW'(PKT_W - 1);
        to_mon_d = shift_q[PKT_W-1];
      end
      StData: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          state_d    = StGap;
          cnt_d      = CntW'(GAP_BITS - 1);
          pkt_sent_d = 1'b1;
        end else begin
          cnt_d    = cnt_q - CntW'(1);
          to_mon_d = shift_d[PKT_W-1];
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (can_start) begin
          // Chain straight into the next packet to keep the period at 1+PKT_W+GAP_BITS
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = StStart;
          to_mon_d = MON_START_LEVEL;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      to_mon_q   <= MON_IDLE_LEVEL;
      busy_q     <= 1'b0;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      to_mon_q   <= to_mon_d;
      busy_q     <= busy_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

endmodule

// File: tb/tb_mon_packet_transmitter.sv
// Directed and random bench for mon_packet_transmitter with a serial receiver model.
module tb_mon_packet_transmitter;

  localparam int PKT_W    = 40;
  localparam int GAP_BITS = 8;
  localparam int PERIOD   = 1 + PKT_W + GAP_BITS;
  localparam int NSTRESS  = 500;

  logic              clk;
  logic              reset;
  logic [PKT_W-1:0]  pkt_data;
  logic              pkt_valid;
  logic              pkt_ready;
  logic              tx_enable;
  logic              to_mon;
  logic              busy;
  logic              pkt_sent;
  logic [2:0]        fifo_level;

  int errors = 0;
  int checks = 0;

  logic [PKT_W-1:0] exp_q [$];
  int               start_cyc_q [$];
  int               lvl_q [$];

  mon_packet_transmitter #(
    .PKT_W      (PKT_W),
    .FIFO_DEPTH (4),
    .GAP_BITS   (GAP_BITS)
  ) dut (
    .mon_clk    (clk),
    .reset      (reset),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .tx_enable  (tx_enable),
    .to_mon     (to_mon),
    .busy       (busy),
    .pkt_sent   (pkt_sent),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Receiver model: decodes frames at negedge, checks data against the scoreboard,
  // gap length, pkt_sent alignment and busy.
  int               rx_cnt = -1;
  int               gap_run = 1000;
  bit               sent_due = 1'b0;
  logic [PKT_W-1:0] rx_sr = '0;
  logic [PKT_W-1:0] last_rx = '0;
  int               rx_count = 0;
  int               ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      rx_cnt   = -1;
      gap_run  = 1000;
      sent_due = 1'b0;
    end else if (rx_cnt < 0) begin
      chk("pkt_sent_idle", pkt_sent, sent_due);
      sent_due = 1'b0;
      if (to_mon === 1'b0) begin
        chk("gap_len_ok", gap_run >= GAP_BITS, 1);
        chk("busy_start", busy, 1);
        start_cyc_q.push_back(ncyc);
        lvl_q.push_back(int'(fifo_level));
        rx_cnt = 0;
      end else begin
        gap_run++;
      end
    end else begin
      chk("pkt_sent_data", pkt_sent, 0);
      chk("busy_data", busy, 1);
      rx_sr = {rx_sr[PKT_W-2:0], to_mon};
      rx_cnt++;
      if (rx_cnt == PKT_W) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rx_data", rx_sr, exp_q.pop_front());
        last_rx  = rx_sr;
        rx_count++;
        rx_cnt   = -1;
        gap_run  = 0;
        sent_due = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [PKT_W-1:0] d, input int budget);
    bit acc = 1'b0;
    pkt_data  = d;
    pkt_valid = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      acc = pkt_ready;
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    chk("push_accepted", acc, 1);
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int i = 0;
    while (rx_count < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk("rx_count_reached", rx_count >= n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bit(input int b, input int budget);
    int i = 0;
    while (rx_cnt != b && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk("data_bit_reached", rx_cnt == b, 1);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PKT_W-1:0] pk [5];
    logic [63:0]      r;
    int               base;
    int               pushed;
    bit               acc;

    reset     = 1'b1;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    tx_enable = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_to_mon", to_mon, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", pkt_ready, 1);
    @(posedge clk);
    #1;

    // Single packet, latency and decode
    tx_enable = 1'b1;
    push(40'hA5_0000_1234, 4);
    @(negedge clk);
    chk("lat_idle_line", to_mon, 1);
    chk("lat_level1", fifo_level, 1);
    @(negedge clk);
    chk("lat_start_bit", to_mon, 0);
    chk("lat_level0", fifo_level, 0);
    chk("lat_busy", busy, 1);
    wait_rx(1, 200);
    chk("t1_decoded", last_rx, 40'hA5_0000_1234);
    cycles(20);

    // Four back-to-back packets: fill, then drain with exact spacing
    pk[0] = 40'h07_1111_2222;
    pk[1] = 40'h0F_3333_4444;
    pk[2] = 40'h1F_5555_6666;
    pk[3] = 40'h2F_7777_8888;
    pk[4] = 40'hC3_9999_AAAA;
    tx_enable = 1'b0;
    for (int k = 0; k < 4; k++) push(pk[k], 2);
    @(negedge clk);
    chk("t2_ready_full", pkt_ready, 0);
    chk("t2_level4", fifo_level, 4);
    @(posedge clk);
    #1;
    start_cyc_q.delete();
    lvl_q.delete();
    base      = rx_count;
    tx_enable = 1'b1;
    wait_rx(base + 4, 400);
    chk("t2_starts", start_cyc_q.size(), 4);
    for (int i = 1; i < start_cyc_q.size(); i++)
      chk("t2_spacing", start_cyc_q[i] - start_cyc_q[i-1], PERIOD);
    for (int i = 0; i < lvl_q.size(); i++) chk("t2_level_at_start", lvl_q[i], 3 - i);
    cycles(20);

    // Full FIFO with pkt_valid held across the pop cycle
    tx_enable = 1'b0;
    for (int k = 0; k < 4; k++) push(pk[k], 2);
    base      = rx_count;
    tx_enable = 1'b1;
    pkt_valid = 1'b1;
    pkt_data  = pk[4];
    @(negedge clk);
    chk("t3_ready_before_pop", pkt_ready, 0);
    chk("t3_level_before_pop", fifo_level, 4);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_level_after_pop", fifo_level, 3);
    chk("t3_ready_after_pop", pkt_ready, 1);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    exp_q.push_back(pk[4]);
    @(negedge clk);
    chk("t3_level_after_push", fifo_level, 4);
    chk("t3_ready_after_push", pkt_ready, 0);
    @(posedge clk);
    #1;
    wait_rx(base + 5, 500);
    cycles(20);

    // tx_enable dropped mid-packet with two more queued
    tx_enable = 1'b0;
    for (int k = 0; k < 3; k++) push(pk[k+1], 2);
    base      = rx_count;
    tx_enable = 1'b1;
    wait_bit(20, 200);
    tx_enable = 1'b0;
    wait_rx(base + 1, 200);
    cycles(40);
    @(negedge clk);
    chk("t4_level_held", fifo_level, 2);
    chk("t4_line_idle", to_mon, 1);
    chk("t4_not_busy", busy, 0);
    chk("t4_no_new_pkt", rx_count, base + 1);
    @(posedge clk);
    #1;
    tx_enable = 1'b1;
    wait_rx(base + 3, 300);
    cycles(20);

    // Reset in the middle of a packet
    push(40'h3C_0F0F_F0F0, 2);
    push(40'h5A_1234_5678, 2);
    base = rx_count;
    wait_bit(10, 200);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_line_idle", to_mon, 1);
    chk("t5_level0", fifo_level, 0);
    chk("t5_ready", pkt_ready, 1);
    chk("t5_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("t5_aborted_not_rx", rx_count, base);
    push(40'h96_ABCD_EF01, 2);
    wait_rx(base + 1, 200);
    chk("t5_clean_tx", last_rx, 40'h96_ABCD_EF01);
    cycles(20);

    // Random push / enable stress
    base   = rx_count;
    pushed = 0;
    for (int c = 0; c < 60000 && pushed < NSTRESS; c++) begin
      if (tx_enable) begin
        if ($urandom_range(0, 63) == 0) tx_enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        tx_enable = 1'b1;
      end
      r         = {$urandom(), $urandom()};
      pkt_data  = r[PKT_W-1:0];
      pkt_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = pkt_valid & pkt_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(pkt_data);
        pushed++;
      end
    end
    pkt_valid = 1'b0;
    tx_enable = 1'b1;
    chk("t6_pushed", pushed, NSTRESS);
    wait_rx(base + NSTRESS, 1000);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
